axi_mem_slave: RTL
==================

// Module: axi_mem_slave
// PURPOSE
// - AXI4 full responder (slave) backed by on-chip word memory; the far end of the s_axi_mosi_t/s_axi_miso_t link.
// - Accepts bursts from DMA/initiator masters, serves writes with byte strobes and reads with backpressure.
// - Used as DMA source/destination memory in subsystem and as scoreboard-visible target in block benches.
// PARAMETERS
// - MEM_WORDS  1024          memory depth in AXI_DATA_WIDTH words (power of 2)
// - BASE_ADDR  32'h0000_0000 byte address of word 0; decode range BASE_ADDR .. BASE_ADDR+MEM_WORDS*BYTES-1
// PORTS
// - aclk      in   1                  clock, all logic on rising edge
// - arst      in   1                  reset, synchronous, active-low
// - axi_mosi  in   s_axi_mosi_t       AW/W/B-ready/AR/R-ready from master
// - axi_miso  out  s_axi_miso_t       AW/W ready, B, AR ready, R to master
// BEHAVIOUR
// - Reset (arst=0 at edge): every axi_miso field 0, both FSMs to IDLE, any burst abandoned; memory contents NOT cleared.
// - All axi_miso fields registered; buser/ruser always 0. BYTES = AXI_DATA_WIDTH/8; word index = (addr-BASE_ADDR)>>log2(BYTES).
// - Write FSM W_IDLE -> W_DATA -> W_RESP:
//   W_IDLE: awready=1 (first high 1 cycle after reset release). AW handshake latches awid/awaddr/awlen/awsize/awburst, beat cnt=0, err=0; awready drops next cycle.
//   W_DATA: wready=1; each W handshake writes lanes with wstrb[i]=1 at current addr; cnt++, addr advances. Beat cnt==awlen ends burst regardless of wlast.
//   wlast=1 on beat<awlen or wlast=0 on beat awlen -> err=1 (burst length still governed by awlen).
//   W_RESP: bvalid=1, bid=latched awid, bresp=SLVERR if err else OKAY; hold until bready; then W_IDLE next cycle.
// - Read FSM R_IDLE -> R_DATA:
//   R_IDLE: arready=1; AR handshake latches ar* fields; first rvalid the next cycle (1-cycle latency).
//   R_DATA: rvalid=1, rid=arid, rdata=full word at current addr, rresp per beat, rlast=1 on beat arlen.
//   rready=0: rvalid/rdata/rresp/rlast/rid held stable. On handshake of last beat -> R_IDLE, rvalid=0 next cycle unless new beat.
// - Address generation (both channels, step = 1<<size):
//   FIXED: address constant. INCR: addr += step, aligned down to size after first beat; no 4KB check.
//   WRAP: container = (len+1)*step, aligned; addr wraps inside container. len not in {1,3,7,15} -> SLVERR all beats, behave as INCR.
//   burst=RESERVED -> SLVERR, behave as INCR. size > log2(BYTES) -> SLVERR, treat size as log2(BYTES).
// - Narrow writes: only strobed lanes written (master supplies lane-correct strobes); narrow reads return full word.
// - Read and write channels fully independent and concurrent; same-word write and read-beat on one edge: read returns pre-write data.
// - Memory index uses low log2(MEM_WORDS) bits of word index (modulo wrap) unless DECERR feature enabled.
// CONFIGURATION
// - AXI_MEM_SLV_DECERR_EN defined: beat address outside decode range -> write beat dropped (no memory update), bresp=DECERR;
//   read beat rdata=0, rresp=DECERR. DECERR has priority over SLVERR. Handshakes/beat counts unchanged.
// - Not defined: no range check; address wraps modulo MEM_WORDS, responses OKAY/SLVERR only.
// TESTING
// - INCR write awid=8'h5 addr 0x10 len=3 WORD data 11,22,33,44 strb F -> bid=5 OKAY; INCR read same -> 11,22,33,44, rlast beat 4 only, rid=arid.
// - WRAP read len=3 WORD addr 0x08 after init word[i]=i -> rdata 2,3,0,1; WRAP len=2 -> rresp SLVERR all 3 beats.
// - Word 0x20=0, write 0xAABBCCDD strb 4'b0101 -> read 0x00BB00DD; FIXED write len=3 to 0x30 -> only last beat data remains.
// - Read len=7, rready low 3 cycles on beat 2 -> rvalid/rdata/rlast stable; 8 beats total; bready low 5 cycles -> bvalid held, bid stable.
// - Write len=3 with wlast on beat 2 -> 4 beats accepted, bresp SLVERR; concurrent write+read to same word -> read gets old value.
// - Addr BASE+MEM_WORDS*BYTES: DECERR_EN -> DECERR, mem unchanged; not defined -> hits word 0 OKAY. arst low mid-read -> rvalid=0, arready=1 after release, memory intact.

Source files
------------

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_DATA) FSMs over one word array.
// Define AXI_MEM_SLV_DECERR_EN to drop out-of-range beats with DECERR instead of wrapping modulo MEM_WORDS.
package s_axi_pkg;
  localparam int unsigned AXI_ID_WIDTH   = 8;
  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned AXI_USER_WIDTH = 1;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]     awid;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;
    logic                        awvalid;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wlast;
    logic                        wvalid;
    logic                        bready;
    logic [AXI_ID_WIDTH-1:0]     arid;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic                        arvalid;
    logic                        rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                        awready;
    logic                        wready;
    logic [AXI_ID_WIDTH-1:0]     bid;
    logic [1:0]                  bresp;
    logic [AXI_USER_WIDTH-1:0]   buser;
    logic                        bvalid;
    logic                        arready;
    logic [AXI_ID_WIDTH-1:0]     rid;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic [AXI_USER_WIDTH-1:0]   ruser;
    logic                        rvalid;
  } s_axi_miso_t;
endpackage

module axi_mem_slave
  import s_axi_pkg::*;
#(
  parameter int unsigned               MEM_WORDS = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        arst,
  input  s_axi_mosi_t axi_mosi,
  output s_axi_miso_t axi_miso
);
  localparam int unsigned BYTES    = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFF_W    = $clog2(BYTES);
  localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
  localparam logic [2:0]  MAX_SIZE = 3'(OFF_W);
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;
  localparam logic [1:0]  BURST_RSVD  = 2'b11;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic [2:0] eff_size(input logic [2:0] size);
    return (size > MAX_SIZE) ? MAX_SIZE : size;
  endfunction

  function automatic logic [1:0] eff_burst(input logic [1:0] burst, input logic [7:0] len);
    if (burst == BURST_FIXED) return BURST_FIXED;
    if (burst == BURST_WRAP && wrap_len_ok(len)) return BURST_WRAP;
    return BURST_INCR;
  endfunction

  function automatic logic cmd_err(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
    return (size > MAX_SIZE) || (burst == BURST_RSVD) || (burst == BURST_WRAP && !wrap_len_ok(len));
  endfunction

  // Burst/size are already the effective values, so only FIXED/INCR/WRAP reach here.
  function automatic addr_t next_addr(input addr_t addr, input logic [2:0] size,
                                      input logic [1:0] burst, input logic [7:0] len);
    addr_t step, aligned, cont;
    step    = addr_t'(1) << size;
    aligned = addr & ~(step - addr_t'(1));
    cont    = (addr_t'(len) + addr_t'(1)) << size;
    case (burst)
      BURST_FIXED: return addr;
      BURST_WRAP:  return (addr & ~(cont - addr_t'(1))) | ((aligned + step) & (cont - addr_t'(1)));
      default:     return aligned + step;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input addr_t a);
    return IDX_W'((a - BASE_ADDR) >> OFF_W);
  endfunction

`ifdef AXI_MEM_SLV_DECERR_EN
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef logic [AXI_ADDR_WIDTH:0] span_t;
  localparam span_t RANGE = span_t'(MEM_WORDS) * span_t'(BYTES);

  function automatic logic in_range(input addr_t a);
    return {1'b0, a - BASE_ADDR} < RANGE;
  endfunction
`endif

  logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  // ---------------- write channel ----------------
  wstate_t                 r_wstate, w_wstate_nxt;
  addr_t                   r_waddr;
  logic [7:0]              r_wlen, r_wcnt;
  logic [2:0]              r_wsize;
  logic [1:0]              r_wburst;
  logic                    r_werr;
  logic                    r_awready, r_wready, r_bvalid;
  logic [AXI_ID_WIDTH-1:0] r_bid;
  logic [1:0]              r_bresp;
  logic                    w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
  logic [1:0]              w_bresp_nxt;
  logic                    w_aw_hs, w_w_hs, w_b_hs, w_wlast_beat, w_wlast_err, w_mem_we;
`ifdef AXI_MEM_SLV_DECERR_EN
  logic                    r_wdec, w_wbeat_in;
  assign w_wbeat_in = in_range(r_waddr);
  assign w_mem_we   = w_w_hs && w_wbeat_in;
`else
  assign w_mem_we   = w_w_hs;
`endif

  assign w_aw_hs      = arst && axi_mosi.awvalid && r_awready;
  assign w_w_hs       = arst && axi_mosi.wvalid && r_wready;
  assign w_b_hs       = arst && r_bvalid && axi_mosi.bready;
  assign w_wlast_beat = (r_wcnt == r_wlen);
  assign w_wlast_err  = (axi_mosi.wlast != w_wlast_beat);

  always_ff @(posedge aclk) begin
    if (!arst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= '0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
      if (w_aw_hs) r_bid <= axi_mosi.awid;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && w_wlast_beat) w_wstate_nxt = W_RESP;
      W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_awready_nxt = (w_wstate_nxt == W_IDLE);
    w_wready_nxt  = (w_wstate_nxt == W_DATA);
    w_bvalid_nxt  = (w_wstate_nxt == W_RESP);
    w_bresp_nxt   = r_bresp;
    // Response is resolved on the closing beat so that beat's own errors are folded in.
    if (r_wstate == W_DATA && w_wstate_nxt == W_RESP) begin
      w_bresp_nxt = (r_werr || w_wlast_err) ? RESP_SLVERR : RESP_OKAY;
`ifdef AXI_MEM_SLV_DECERR_EN
      if (r_wdec || !w_wbeat_in) w_bresp_nxt = RESP_DECERR;
`endif
    end
  end

  always_ff @(posedge aclk) begin
    if (w_aw_hs) begin
      r_waddr  <= axi_mosi.awaddr;
      r_wlen   <= axi_mosi.awlen;
      r_wsize  <= eff_size(axi_mosi.awsize);
      r_wburst <= eff_burst(axi_mosi.awburst, axi_mosi.awlen);
      r_wcnt   <= '0;
      r_werr   <= cmd_err(axi_mosi.awsize, axi_mosi.awburst, axi_mosi.awlen);
`ifdef AXI_MEM_SLV_DECERR_EN
      r_wdec   <= 1'b0;
`endif
    end else if (w_w_hs) begin
      r_waddr  <= next_addr(r_waddr, r_wsize, r_wburst, r_wlen);
      r_wcnt   <= r_wcnt + 8'd1;
      r_werr   <= r_werr || w_wlast_err;
`ifdef AXI_MEM_SLV_DECERR_EN
      r_wdec   <= r_wdec || !w_wbeat_in;
`endif
    end
  end

  always_ff @(posedge aclk) begin
    if (w_mem_we) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (axi_mosi.wstrb[i]) r_mem[word_idx(r_waddr)][8*i +: 8] <= axi_mosi.wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_t                   r_rstate, w_rstate_nxt;
  addr_t                     r_raddr, w_rbeat_addr;
  logic [7:0]                r_rlen, r_rcnt, w_rbeat_cnt, w_rbeat_len;
  logic [2:0]                r_rsize;
  logic [1:0]                r_rburst;
  logic                      r_rerr, w_rbeat_err;
  logic                      r_arready, r_rvalid, r_rlast;
  logic [AXI_ID_WIDTH-1:0]   r_rid;
  logic [AXI_DATA_WIDTH-1:0] r_rdata, w_rbeat_data;
  logic [1:0]                r_rresp, w_rbeat_resp;
  logic                      w_arready_nxt, w_rvalid_nxt;
  logic                      w_ar_hs, w_r_hs, w_r_load;

  assign w_ar_hs  = arst && axi_mosi.arvalid && r_arready;
  assign w_r_hs   = arst && r_rvalid && axi_mosi.rready;
  assign w_r_load = w_ar_hs || (w_r_hs && !r_rlast);

  always_ff @(posedge aclk) begin
    if (!arst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_rlast   <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      if (w_ar_hs) r_rid <= axi_mosi.arid;
      if (w_r_load) begin
        r_rdata <= w_rbeat_data;
        r_rresp <= w_rbeat_resp;
        r_rlast <= (w_rbeat_cnt == w_rbeat_len);
      end
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // The next beat is fetched on the edge that accepts AR or the previous beat,
  // so a same-edge write to that word is not yet visible.
  always_comb begin
    w_arready_nxt = (w_rstate_nxt == R_IDLE);
    w_rvalid_nxt  = (w_rstate_nxt == R_DATA);
    w_rbeat_addr  = w_ar_hs ? axi_mosi.araddr : next_addr(r_raddr, r_rsize, r_rburst, r_rlen);
    w_rbeat_cnt   = w_ar_hs ? 8'd0 : r_rcnt + 8'd1;
    w_rbeat_len   = w_ar_hs ? axi_mosi.arlen : r_rlen;
    w_rbeat_err   = w_ar_hs ? cmd_err(axi_mosi.arsize, axi_mosi.arburst, axi_mosi.arlen) : r_rerr;
    w_rbeat_data  = r_mem[word_idx(w_rbeat_addr)];
    w_rbeat_resp  = w_rbeat_err ? RESP_SLVERR : RESP_OKAY;
`ifdef AXI_MEM_SLV_DECERR_EN
    if (!in_range(w_rbeat_addr)) begin
      w_rbeat_data = '0;
      w_rbeat_resp = RESP_DECERR;
    end
`endif
  end

  always_ff @(posedge aclk) begin
    if (w_ar_hs) begin
      r_rlen   <= axi_mosi.arlen;
      r_rsize  <= eff_size(axi_mosi.arsize);
      r_rburst <= eff_burst(axi_mosi.arburst, axi_mosi.arlen);
      r_rerr   <= cmd_err(axi_mosi.arsize, axi_mosi.arburst, axi_mosi.arlen);
    end
    if (w_r_load) begin
      r_raddr <= w_rbeat_addr;
      r_rcnt  <= w_rbeat_cnt;
    end
  end

  always_comb begin
    axi_miso         = '0;
    axi_miso.awready = r_awready;
    axi_miso.wready  = r_wready;
    axi_miso.bid     = r_bid;
    axi_miso.bresp   = r_bresp;
    axi_miso.bvalid  = r_bvalid;
    axi_miso.arready = r_arready;
    axi_miso.rid     = r_rid;
    axi_miso.rdata   = r_rdata;
    axi_miso.rresp   = r_rresp;
    axi_miso.rlast   = r_rlast;
    axi_miso.rvalid  = r_rvalid;
  end

endmodule
